// File: rtl/debounce_multi_if.sv
// ============================================================================
//  Module      : debounce_multi_if
//  Description : Signal bundle between a button-sampling master (board / test
//                harness) and the debounce_multi filter.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Signals
//    en     sampling strobe, one clk wide              master -> slave
//    din    [N] raw asynchronous button levels         master -> slave
//    dout   [N] debounced levels                       slave  -> master
//    rise   [N] one-cycle 0->1 pulse on dout           slave  -> master
//    fall   [N] one-cycle 1->0 pulse on dout           slave  -> master
//    press  [N] rise OR auto-repeat pulse              slave  -> master
// ============================================================================
`default_nettype none

interface debounce_multi_if #(
  parameter int N = 5
) ();

  logic         en;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press;

  modport master (
    output en,
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  press
  );

  modport slave (
    input  en,
    input  din,
    output dout,
    output rise,
    output fall,
    output press
  );

endinterface

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel button debouncer. Each channel has a 2-flop
//                synchronizer, a symmetric counter filter evaluated on the
//                slow sampling strobe, registered one-cycle rise/fall pulses
//                and an optional auto-repeat strobe for held buttons.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock
//    rst        in   synchronous, active-high reset
//    bus.en     in   sampling strobe (one clk wide)
//    bus.din    in   [N] raw button levels, 1 = pressed
//    bus.dout   out  [N] debounced levels
//    bus.rise   out  [N] one-cycle pulse on dout 0->1
//    bus.fall   out  [N] one-cycle pulse on dout 1->0
//    bus.press  out  [N] rise OR auto-repeat pulse
// ============================================================================
`default_nettype none

module debounce_multi #(
  parameter int N            = 5,
  parameter int STABLE       = 3,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 20
) (
  input  logic            clk,
  input  logic            rst,
  debounce_multi_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cnt_w = $clog2(STABLE + 1);
  localparam int c_rc_w  = $clog2(REPEAT_DELAY + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // The repeat counter fires on the strobe that would take it to
  // REPEAT_DELAY, so it never actually holds that value and cannot wrap.
  localparam logic [c_rc_w-1:0]  c_rc_last  = c_rc_w'(REPEAT_DELAY - 1);
  localparam logic [c_rc_w-1:0]  c_rc_one   = c_rc_w'(1);

  // After a repeat the counter restarts REPEAT_RATE strobes short of the
  // threshold. A rate at or above the delay cannot be represented that way,
  // so it restarts from zero instead.
  localparam int c_reload_int =
    (REPEAT_RATE >= REPEAT_DELAY) ? 0 : (REPEAT_DELAY - REPEAT_RATE);
  localparam logic [c_rc_w-1:0]  c_rc_reload = c_rc_w'(c_reload_int);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0]         sync1_q;
  logic [N-1:0]         sync2_q;

  logic [N-1:0]         dout_q,  dout_d;
  logic [N-1:0]         rise_q,  rise_d;
  logic [N-1:0]         fall_q,  fall_d;
  logic [N-1:0]         press_q, press_d;
  logic [N-1:0]         rep_d;

  logic [c_cnt_w-1:0]   cnt_q [N];
  logic [c_cnt_w-1:0]   cnt_d [N];
  logic [c_rc_w-1:0]    rc_q  [N];
  logic [c_rc_w-1:0]    rc_d  [N];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    dout_d  = dout_q;
    rise_d  = '0;
    fall_d  = '0;
    rep_d   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      rc_d[i]  = rc_q[i];
    end

    if (bus.en) begin
      for (int i = 0; i < N; i++) begin
        // Filter: any sample agreeing with the current level restarts the
        // count, so only STABLE consecutive contrary samples are accepted.
        if (sync2_q[i] == dout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == c_cnt_last) begin
          dout_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + c_cnt_one;
        end

        // Auto-repeat: only counts strobes on which the button was already
        // accepted as held and stays held, so a repeat can never coincide
        // with the rise or the fall of the same channel.
        if (REPEAT_EN != 0) begin
          if (rise_d[i] || fall_d[i] || !dout_q[i]) begin
            rc_d[i] = '0;
          end else if (rc_q[i] == c_rc_last) begin
            rep_d[i] = 1'b1;
            rc_d[i]  = c_rc_reload;
          end else begin
            rc_d[i] = rc_q[i] + c_rc_one;
          end
        end else begin
          rc_d[i] = '0;
        end
      end
    end

    press_d = rise_d | rep_d;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dout_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        rc_q[i]  <= '0;
      end
    end else begin
      // Synchronizer runs every clock, independent of the strobe.
      sync1_q <= bus.din;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
      // Pulses are recomputed every clock, so they drop after one cycle
      // even when the strobe is held high.
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
        rc_q[i]  <= rc_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.dout  = dout_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.press = press_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Self-checking bench for debounce_multi. A strobed instance
//                (STABLE=3, auto-repeat DELAY=4 RATE=2) is driven from a
//                table of per-strobe records; a second instance (STABLE=1,
//                no repeat, strobe held high) is driven per clock.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

  typedef struct packed {
    logic       rst_before;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] press;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_f;

  int n_vec = 0;
  int n_err = 0;

  vec_t sbq  [$];
  vec_t tbl  [$];
  vec_t ftbl [$];

  debounce_multi_if #(.N(4)) m_bus ();
  debounce_multi_if #(.N(4)) f_bus ();

  debounce_multi #(
    .N            (4),
    .STABLE       (3),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .bus (m_bus)
  );

  debounce_multi #(
    .N            (4),
    .STABLE       (1),
    .REPEAT_EN    (0),
    .REPEAT_DELAY (100),
    .REPEAT_RATE  (20)
  ) u_fast (
    .clk (clk),
    .rst (rst_f),
    .bus (f_bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] di,
                              input logic [3:0] dt, input logic [3:0] ri,
                              input logic [3:0] fa, input logic [3:0] pr);
    vec_t v;
    v.rst_before = r;
    v.din        = di;
    v.dout       = dt;
    v.rise       = ri;
    v.fall       = fa;
    v.press      = pr;
    return v;
  endfunction

  task automatic check(input string tag, input int idx,
                       input logic [3:0] dt, input logic [3:0] ri,
                       input logic [3:0] fa, input logic [3:0] pr);
    vec_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL %s[%0d]: got dout=%b rise=%b fall=%b press=%b, expected record missing",
               tag, idx, dt, ri, fa, pr);
      return;
    end
    e = sbq.pop_front();
    if ({dt, ri, fa, pr} !== {e.dout, e.rise, e.fall, e.press}) begin
      n_err++;
      $display("FAIL %s[%0d]: got dout=%b rise=%b fall=%b press=%b, expected dout=%b rise=%b fall=%b press=%b",
               tag, idx, dt, ri, fa, pr, e.dout, e.rise, e.fall, e.press);
    end
  endtask

  // One sampling period of the strobed instance: settle din through the
  // synchronizer, fire a one-clock strobe, check the strobe edge and the
  // following edge (pulses must be gone, level must hold).
  task automatic run_strobe(input vec_t v, input int idx);
    vec_t z;
    if (v.rst_before) begin
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sbq.push_back(mk(1'b0, v.din, 4'b0, 4'b0, 4'b0, 4'b0));
      check("reset_mid", idx, m_bus.dout, m_bus.rise, m_bus.fall, m_bus.press);
    end
    @(negedge clk);
    m_bus.din = v.din;
    repeat (4) @(negedge clk);
    m_bus.en = 1'b1;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    check("strobe", idx, m_bus.dout, m_bus.rise, m_bus.fall, m_bus.press);
    @(negedge clk);
    m_bus.en = 1'b0;
    z = mk(1'b0, v.din, v.dout, 4'b0, 4'b0, 4'b0);
    sbq.push_back(z);
    @(posedge clk);
    #1;
    check("after", idx, m_bus.dout, m_bus.rise, m_bus.fall, m_bus.press);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- strobed instance table: r, din, dout, rise, fall, press ----------
    // press on channel 0 held
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001));
    // channel 1 sees 1,1,0,1,1,1; channel 0 keeps repeating meanwhile
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0011));
    // channel 0 release with a 0,1,0 bounce
    tbl.push_back(mk(0, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000));
    // channel 1 release; no repeat on the fall strobe
    tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    // channel 2 held: press at acceptance, +4, +6, +8, +10, +12
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100));
    for (int k = 1; k <= 12; k++) begin
      tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                       ((k >= 4) && (k % 2 == 0)) ? 4'b0100 : 4'b0000));
    end
    // release: one more repeat while still accepted, none on/after the fall
    tbl.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // all channels together
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000));
    // reset in the middle of a press count, button held through it
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111));

    // ---- STABLE=1 instance, strobe held high, one record per clock --------
    ftbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0101));
    ftbl.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0011, 4'b0101, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0011, 4'b0101, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, 4'b0100, 4'b0010));
    ftbl.push_back(mk(0, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    ftbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000));
    ftbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

    // ---- reset ------------------------------------------------------------
    rst       = 1'b1;
    rst_f     = 1'b1;
    m_bus.en  = 1'b0;
    m_bus.din = 4'b0000;
    f_bus.en  = 1'b0;
    f_bus.din = 4'b0000;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    rst_f    = 1'b0;
    f_bus.en = 1'b1;
    sbq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    check("reset_main", 0, m_bus.dout, m_bus.rise, m_bus.fall, m_bus.press);
    sbq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    check("reset_fast", 0, f_bus.dout, f_bus.rise, f_bus.fall, f_bus.press);

    // ---- strobed instance ------------------------------------------------
    for (int i = 0; i < tbl.size(); i++) begin
      run_strobe(tbl[i], i);
    end

    // ---- continuous-strobe instance --------------------------------------
    for (int i = 0; i < ftbl.size(); i++) begin
      @(negedge clk);
      f_bus.din = ftbl[i].din;
      sbq.push_back(ftbl[i]);
      @(posedge clk);
      #1;
      check("fast", i, f_bus.dout, f_bus.rise, f_bus.fall, f_bus.press);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- N-channel, parametrised successor to the single-channel button debouncer.
- Each channel has:
  - a 2-flop input synchronizer;
  - a symmetric counter-based filter, so both press and release must be stable for STABLE samples;
  - one-cycle rise/fall pulses;
  - an optional auto-repeat press strobe for held buttons (e.g. snake direction keys).
- Sits between raw board buttons and game control logic; sampled by a shared slow strobe.

Parameters:
- N, 5, number of independent button channels (>=1).
- STABLE, 3, consecutive differing samples required to accept a new level (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat on press[]; 0 makes press[] identical to rise[].
- REPEAT_DELAY, 100, strobes held after rise before the first repeat pulse (>=1).
- REPEAT_RATE, 20, strobes between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sampling strobe, one clk cycle wide, slow (~5 ms period)
- din  in  N  raw asynchronous button levels, 1 = pressed
- dout  out  N  debounced levels
- rise  out  N  one-cycle pulse when dout[i] goes 0->1
- fall  out  N  one-cycle pulse when dout[i] goes 1->0
- press  out  N  rise[i] OR auto-repeat pulse (one cycle each)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: sync flops, counters, dout, rise, fall and press all 0. Channels come up in the released state.
- Synchronizer: s1<=din, s2<=s1 every clk, not gated by en. It is reset to 0.
- Filter, per channel, evaluated only on clk edges with en=1, using counter cnt of width clog2(STABLE+1):
  - s2==dout: cnt<=0. Any contrary sample restarts the count; there is no hysteresis leak.
  - s2!=dout and cnt==STABLE-1: dout<=s2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- STABLE=1: the first differing sample is accepted.
- Edge pulses: rise/fall are registered on the same edge dout changes. They are high for exactly one clk, then return to 0, even if en is held high.
- Latency: a din change at edge t is visible in s2 after edge t+2. dout changes on the STABLE-th en strobe at or after that point.
- Auto-repeat (REPEAT_EN=1), per channel, using counter rc:
  - rc<=0 on rise.
  - While dout=1, each en strobe increments rc.
  - When rc reaches REPEAT_DELAY: press pulses and rc reloads to REPEAT_DELAY-REPEAT_RATE.
  - Net effect: first repeat after REPEAT_DELAY strobes, then every REPEAT_RATE strobes.
  - On fall or dout=0: rc<=0 and no repeat.
  - rc width is clog2(REPEAT_DELAY+1). It saturates and never wraps.
- press and rise coincide only on the initial press. A repeat never fires on the same edge as rise.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- en=0: no state changes except the synchronizer; all pulse outputs 0 after their one cycle.
- rst during a count or hold: every counter and output clears immediately. A button still held after reset produces a fresh rise after sync latency plus STABLE strobes.
- Glitch shorter than one strobe period between samples: ignored.
- Glitch sampled fewer than STABLE times: cnt resets and dout is unchanged.

Test Plan:
- N=4, STABLE=3, en every 10 clks; din[0] 0->1 held -> dout[0]=1 and rise[0]=1 on the 3rd strobe after sync (2 clks), both on the same edge. rise[0] is high for 1 clk only; other channels stay 0.
- din[1] pattern of 1,1,0,1,1,1 across strobes -> no change until the final 3 consecutive 1s. dout[1] rises on strobe 6; no spurious pulse.
- Release after stable press: din[0] 1->0 -> fall[0] on the 3rd strobe, dout[0]=0, rise[0] stays 0. A bounce 0,1,0 during release restarts the count.
- REPEAT_EN=1, DELAY=4, RATE=2; hold din[2] for 12 strobes after acceptance -> press[2] at acceptance, then at +4, +6, +8, +10 and +12 strobes. Release -> no further press.
- din=4'b1111 simultaneous -> all rise bits on the same edge. Assert rst at strobe 2 of the count -> all outputs 0. Holding through reset gives rise on the 3rd post-reset strobe.
- STABLE=1 and en held high continuously -> dout follows s2 with 1-clk filter delay. rise/fall remain single-cycle.
